// File: rtl/sevenseg_scan_driver_if.sv
// Interface between the datapath (master) and the seven-segment scan driver (slave).
interface sevenseg_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  blank_lz;
  logic                  load;
  logic [6:0]            segments;
  logic                  dp;
  logic [N_DIGITS-1:0]   anodes;
  logic                  frame_tick;

  modport master (
    output value_in, dp_in, digit_en, blank_lz, load,
    input  segments, dp, anodes, frame_tick
  );

  modport slave (
    input  value_in, dp_in, digit_en, blank_lz, load,
    output segments, dp, anodes, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver with leading-zero blanking
// and a double-buffered value/dp/enable shadow that only changes on frame boundaries.
module sevenseg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_driver_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] pol7(input logic [6:0] v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [N_DIGITS-1:0] pol_an(input logic [N_DIGITS-1:0] v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic pol1(input logic v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  logic [CW-1:0]           cnt_p0;
  logic [IW-1:0]           idx_p0;
  logic [4*N_DIGITS-1:0]   shadow_val, pend_val;
  logic [N_DIGITS-1:0]     shadow_dp, pend_dp;
  logic [N_DIGITS-1:0]     shadow_en, pend_en;
  logic                    pend_flag;
  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [N_DIGITS-1:0]     an_p1;
  logic                    tick_p1;

  logic                    wrap, boundary;
  logic                    lit, blank, zero_run;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;
  logic                    dp_raw;
  logic [N_DIGITS-1:0]     an_raw;
  int                      cur;

  assign wrap     = (cnt_p0 == CNT_LAST);
  assign boundary = wrap && (idx_p0 == IDX_LAST);

  // Stage p0 -> p1: decode the digit selected by the current scan index
  always_comb begin
    cur      = int'(idx_p0);
    nib      = shadow_val[cur*4 +: 4];
    lit      = shadow_en[cur];
    zero_run = 1'b1;
    blank    = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (shadow_val[i*4 +: 4] == 4'h0);
      if (i == cur) blank = zero_run & bus.blank_lz;
    end
    seg_raw = (lit && !blank) ? hex7(nib) : 7'h00;
    dp_raw  = lit & shadow_dp[cur];
    an_raw  = lit ? (N_DIGITS'(1) << cur) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      // Enables come up set so the cleared value is visibly "0" after reset.
      shadow_en  <= '1;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_flag  <= 1'b0;
      tick_p1    <= 1'b0;
      seg_p1     <= pol7(7'h00);
      dp_p1      <= pol1(1'b0);
      an_p1      <= pol_an('0);
    end else begin
      cnt_p0  <= wrap ? '0 : cnt_p0 + CW'(1);
      if (wrap) idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
      tick_p1 <= boundary;
      if (boundary) begin
        if (bus.load) begin
          shadow_val <= bus.value_in;
          shadow_dp  <= bus.dp_in;
          shadow_en  <= bus.digit_en;
        end else if (pend_flag) begin
          shadow_val <= pend_val;
          shadow_dp  <= pend_dp;
          shadow_en  <= pend_en;
        end
        pend_flag <= 1'b0;
      end else if (bus.load) begin
        pend_val  <= bus.value_in;
        pend_dp   <= bus.dp_in;
        pend_en   <= bus.digit_en;
        pend_flag <= 1'b1;
      end
      seg_p1 <= pol7(seg_raw);
      dp_p1  <= pol1(dp_raw);
      an_p1  <= pol_an(an_raw);
    end
  end

  assign bus.segments   = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.anodes     = an_p1;
  assign bus.frame_tick = tick_p1;
endmodule
